// File: rtl/bus_sequencer.sv
// bus_sequencer: microcode-style controller for the 16-bit tri-state bus
// datapath (registers A-D, input port, adder on A+B). Accepts one LOAD,
// MOVE or ADD instruction over a start/ready handshake and expands it into
// single-cycle bus transfers with at most one bus driver per cycle.
// Optional feature macro: BUS_SEQ_SETTLE_EN
//   defined   -> adder drives the bus for one SETTLE cycle before write-back
//   undefined -> write-back happens in the first adder-drive cycle
module bus_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [1:0]       dst,
    input  logic [1:0]       src1,
    input  logic [1:0]       src2,
    input  logic [WIDTH-1:0] imm,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] inData,
    output logic             enbIn,
    output logic             enbA,
    output logic             enbB,
    output logic             enbC,
    output logic             enbD,
    output logic             ldA,
    output logic             ldB,
    output logic             ldC,
    output logic             ldD,
    output logic             enbAdd,
    output logic             enbBusA
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_B = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MOV    = 3'd2,
        ST_OPA    = 3'd3,
        ST_OPB    = 3'd4,
        ST_SETTLE = 3'd5,
        ST_WB     = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       dst_reg, src1_reg, src2_reg;
    logic [WIDTH-1:0] imm_reg;

    // Register-file bus driver / load selection produced by the decoder
    logic       enb_valid, ld_valid;
    logic [1:0] enb_sel, ld_sel;
    logic [3:0] enb_vec, ld_vec;

    // ADD operand normalisation: p is moved into A, q into B. Swapping when
    // src1 is B or src2 is A avoids moving an operand out of the scratch
    // register it already occupies.
    logic       swap_ops;
    logic [1:0] p_sel, q_sel;

    assign swap_ops = (src1_reg == REG_B) || (src2_reg == REG_A);
    assign p_sel    = swap_ops ? src2_reg : src1_reg;
    assign q_sel    = swap_ops ? src1_reg : src2_reg;

    // State register plus instruction latch; inputs are sampled only at acceptance
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            dst_reg   <= 2'd0;
            src1_reg  <= 2'd0;
            src2_reg  <= 2'd0;
            imm_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                dst_reg  <= dst;
                src1_reg <= src1;
                src2_reg <= src2;
                imm_reg  <= imm;
            end
        end
    end

    // Next-state and Moore output decode from registered state and latched instruction
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        enbIn      = 1'b0;
        enbAdd     = 1'b0;
        enbBusA    = 1'b0;
        enb_valid  = 1'b0;
        enb_sel    = 2'd0;
        ld_valid   = 1'b0;
        ld_sel     = 2'd0;
        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    case (op)
                        OP_NOP:  state_next = ST_DONE;
                        OP_LOAD: state_next = ST_LOAD;
                        OP_MOVE: state_next = ST_MOV;
                        OP_ADD:  state_next = ST_OPA;
                        default: state_next = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: begin
                enbIn      = 1'b1;
                ld_valid   = 1'b1;
                ld_sel     = dst_reg;
                state_next = ST_DONE;
            end
            ST_MOV: begin
                // A self-move would be a no-op transfer; keep the bus quiet instead
                if (src1_reg != dst_reg) begin
                    enb_valid = 1'b1;
                    enb_sel   = src1_reg;
                    ld_valid  = 1'b1;
                    ld_sel    = dst_reg;
                end
                state_next = ST_DONE;
            end
            ST_OPA: begin
                if (p_sel != REG_A) begin
                    enb_valid = 1'b1;
                    enb_sel   = p_sel;
                    ld_valid  = 1'b1;
                    ld_sel    = REG_A;
                end
                state_next = ST_OPB;
            end
            ST_OPB: begin
                if (q_sel != REG_B) begin
                    enb_valid = 1'b1;
                    enb_sel   = q_sel;
                    ld_valid  = 1'b1;
                    ld_sel    = REG_B;
                end
`ifdef BUS_SEQ_SETTLE_EN
                state_next = ST_SETTLE;
`else
                state_next = ST_WB;
`endif
            end
            ST_SETTLE: begin
                // Unreachable unless the settle cycle is configured in
                enbAdd     = 1'b1;
                enbBusA    = 1'b1;
                state_next = ST_WB;
            end
            ST_WB: begin
                enbAdd     = 1'b1;
                enbBusA    = 1'b1;
                ld_valid   = 1'b1;
                ld_sel     = dst_reg;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One-hot expansion of the driver/load selections; a single select
    // guarantees at most one register drives the bus
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg_strobes
            assign enb_vec[gi] = enb_valid && (enb_sel == 2'(gi));
            assign ld_vec[gi]  = ld_valid  && (ld_sel  == 2'(gi));
        end
    endgenerate

    assign enbA   = enb_vec[0];
    assign enbB   = enb_vec[1];
    assign enbC   = enb_vec[2];
    assign enbD   = enb_vec[3];
    assign ldA    = ld_vec[0];
    assign ldB    = ld_vec[1];
    assign ldC    = ld_vec[2];
    assign ldD    = ld_vec[3];
    assign inData = imm_reg;

endmodule

// File: tb/tb_bus_sequencer.sv
// Testbench for bus_sequencer: models the tri-state datapath driven by the
// controller's strobes and scoreboards latency, transfer counts and register
// contents at every done pulse.
module tb_bus_sequencer;

    localparam int W = 16;
`ifdef BUS_SEQ_SETTLE_EN
    localparam int ADD_LAT = 5;
`else
    localparam int ADD_LAT = 4;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0, dst = 2'd0, src1 = 2'd0, src2 = 2'd0;
    logic [W-1:0]  imm = '0;
    logic          ready, done, enbIn, enbA, enbB, enbC, enbD;
    logic          ldA, ldB, ldC, ldD, enbAdd, enbBusA;
    logic [W-1:0]  inData;

    bus_sequencer #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .dst(dst),
        .src1(src1), .src2(src2), .imm(imm), .ready(ready), .done(done),
        .inData(inData), .enbIn(enbIn), .enbA(enbA), .enbB(enbB),
        .enbC(enbC), .enbD(enbD), .ldA(ldA), .ldB(ldB), .ldC(ldC),
        .ldD(ldD), .enbAdd(enbAdd), .enbBusA(enbBusA)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Datapath model: tri-state bus, four registers, adder on A+B
    logic [W-1:0] dReg [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic [W-1:0] bus;
    always_comb begin
        bus = '0;
        if (enbIn)                 bus = inData;
        else if (enbA)             bus = dReg[0];
        else if (enbB)             bus = dReg[1];
        else if (enbC)             bus = dReg[2];
        else if (enbD)             bus = dReg[3];
        else if (enbBusA && enbAdd) bus = dReg[0] + dReg[1];
    end
    always @(posedge clock) begin
        if (ldA) dReg[0] <= bus;
        if (ldB) dReg[1] <= bus;
        if (ldC) dReg[2] <= bus;
        if (ldD) dReg[3] <= bus;
    end

    typedef struct {
        string        name;
        int           cap;
        int           lat;
        int           tr;
        int           lds;
        logic [W-1:0] r [4];
    } exp_t;

    exp_t sbq [$];

    // Monitor: bus-contention check every cycle, scoreboard pop on done
    int trCnt = 0;
    int ldCnt = 0;
    always @(negedge clock) begin
        check("single_bus_driver", ($countones({enbIn, enbA, enbB, enbC, enbD, enbBusA}) <= 1), 1);
        if (reset) begin
            trCnt = 0;
            ldCnt = 0;
        end else begin
            if (enbIn | enbA | enbB | enbC | enbD) trCnt++;
            if (ldA | ldB | ldC | ldD) ldCnt++;
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check({e.name, "_latency"}, cyc - e.cap + 1, e.lat);
                    check({e.name, "_transfers"}, trCnt, e.tr);
                    check({e.name, "_loads"}, ldCnt, e.lds);
                    check({e.name, "_ready_low"}, ready, 0);
                    check({e.name, "_regA"}, dReg[0], e.r[0]);
                    check({e.name, "_regB"}, dReg[1], e.r[1]);
                    check({e.name, "_regC"}, dReg[2], e.r[2]);
                    check({e.name, "_regD"}, dReg[3], e.r[3]);
                    $display("txn %-10s lat=%0d tr=%0d lds=%0d A=%04h B=%04h C=%04h D=%04h",
                             e.name, cyc - e.cap + 1, trCnt, ldCnt,
                             dReg[0], dReg[1], dReg[2], dReg[3]);
                end
                trCnt = 0;
                ldCnt = 0;
            end
        end
    end

    // Issue one instruction, push its expectation, then pulse a junk start
    // while busy (must be ignored) and wait for ready to return
    task automatic issue(input string nm, input logic [1:0] o, input logic [1:0] d,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [W-1:0] im,
                         input int lat, input int tr, input int lds,
                         input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic [W-1:0] ec, input logic [W-1:0] ed);
        exp_t e;
        int n;
        op = o; dst = d; src1 = s1; src2 = s2; imm = im; start = 1'b1;
        @(posedge clock); #1;
        e.name = nm; e.cap = cyc; e.lat = lat; e.tr = tr; e.lds = lds;
        e.r[0] = ea; e.r[1] = eb; e.r[2] = ec; e.r[3] = ed;
        sbq.push_back(e);
        op = 2'b01; dst = 2'b00; src1 = 2'b11; src2 = 2'b11; imm = 16'hDEAD;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout %s: ready=%0b, required 1", nm, ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_ready", ready, 1);
        check("reset_strobes", {done, enbIn, enbA, enbB, enbC, enbD, ldA, ldB, ldC, ldD, enbAdd, enbBusA}, 0);
        check("reset_inData", inData, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        //    name         op     dst    s1     s2     imm       lat      tr lds  A        B        C        D
        issue("load_A",    2'b01, 2'd0, 2'd0, 2'd0, 16'h004F, 2,       1, 1, 16'h004F, 16'h0000, 16'h0000, 16'h0000);
        issue("load_C",    2'b01, 2'd2, 2'd0, 2'd0, 16'h000F, 2,       1, 1, 16'h004F, 16'h0000, 16'h000F, 16'h0000);
        issue("load_B",    2'b01, 2'd1, 2'd0, 2'd0, 16'h003F, 2,       1, 1, 16'h004F, 16'h003F, 16'h000F, 16'h0000);
        issue("load_D",    2'b01, 2'd3, 2'd0, 2'd0, 16'h0028, 2,       1, 1, 16'h004F, 16'h003F, 16'h000F, 16'h0028);
        issue("add_A_AB",  2'b11, 2'd0, 2'd0, 2'd1, 16'h0000, ADD_LAT, 0, 1, 16'h008E, 16'h003F, 16'h000F, 16'h0028);
        issue("add_C_BD",  2'b11, 2'd2, 2'd1, 2'd3, 16'h0000, ADD_LAT, 1, 2, 16'h0028, 16'h003F, 16'h0067, 16'h0028);
        issue("add_D_DC",  2'b11, 2'd3, 2'd3, 2'd2, 16'h0000, ADD_LAT, 2, 3, 16'h0028, 16'h0067, 16'h0067, 16'h008F);
        issue("move_B_C",  2'b10, 2'd1, 2'd2, 2'd0, 16'h0000, 2,       1, 1, 16'h0028, 16'h0067, 16'h0067, 16'h008F);
        issue("move_A_A",  2'b10, 2'd0, 2'd0, 2'd0, 16'h0000, 2,       0, 0, 16'h0028, 16'h0067, 16'h0067, 16'h008F);
        issue("nop",       2'b00, 2'd0, 2'd0, 2'd0, 16'h0000, 1,       0, 0, 16'h0028, 16'h0067, 16'h0067, 16'h008F);
        issue("load_A_ff", 2'b01, 2'd0, 2'd0, 2'd0, 16'hFFFF, 2,       1, 1, 16'hFFFF, 16'h0067, 16'h0067, 16'h008F);
        issue("load_B_1",  2'b01, 2'd1, 2'd0, 2'd0, 16'h0001, 2,       1, 1, 16'hFFFF, 16'h0001, 16'h0067, 16'h008F);
        issue("add_B_BA",  2'b11, 2'd1, 2'd1, 2'd0, 16'h0000, ADD_LAT, 0, 1, 16'hFFFF, 16'h0000, 16'h0067, 16'h008F);

        // Abort an ADD D=A+C during OPB; no done may follow
        op = 2'b11; dst = 2'd3; src1 = 2'd0; src2 = 2'd2; start = 1'b1;
        @(posedge clock); #1;          // OPA
        start = 1'b0;
        @(posedge clock); #1;          // OPB
        check("opb_ldB", ldB, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_ready", ready, 1);
        check("abort_strobes", {done, enbIn, enbA, enbB, enbC, enbD, ldA, ldB, ldC, ldD, enbAdd, enbBusA}, 0);
        check("abort_inData", inData, 0);
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;

        // OPB copied C into B on the reset edge; D untouched by the aborted ADD
        issue("load_D_rec", 2'b01, 2'd3, 2'd0, 2'd0, 16'h1234, 2,      1, 1, 16'hFFFF, 16'h0067, 16'h0067, 16'h1234);

        repeat (4) @(posedge clock);
        #1;
        check("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Microcode-style controller that drives the control inputs of the 16-bit tri-state bus datapath (registers A–D, input port, adder on A+B). It accepts one instruction at a time over a start/ready handshake: LOAD immediate, MOVE register-to-register, or ADD into any register. It expands each instruction into single-cycle bus transfers and guarantees at most one bus driver per cycle. It replaces hand-sequenced enable/load waveforms at the datapath's control port.

## Interface
Parameters:
- `WIDTH`, 16, width of the immediate and `inData`.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: instruction valid; accepted only when `ready`=1.
- `op` in 2: opcode. 00 NOP, 01 LOAD, 10 MOVE, 11 ADD.
- `dst` in 2: destination register. 00 A, 01 B, 10 C, 11 D.
- `src1`, `src2` in 2 each: source registers. `src2` is used by ADD only.
- `imm` in WIDTH: immediate value for LOAD.
- `ready` out 1: idle, can accept an instruction.
- `done` out 1: one-cycle pulse when an instruction retires.
- `inData` out WIDTH: value for the datapath input port.
- `enbIn`, `enbA`, `enbB`, `enbC`, `enbD` out 1 each: bus driver enables.
- `ldA`, `ldB`, `ldC`, `ldD` out 1 each: register load strobes. The datapath captures on the next rising edge.
- `enbAdd`, `enbBusA` out 1 each: adder enable and adder-to-bus driver.

## Operation
- States: IDLE, LOAD, MOV, OPA, OPB, SETTLE, WB, DONE. Moore outputs, decoded from registered state plus the latched instruction.
- IDLE: `ready`=1. On `start`, latch op/dst/src1/src2/imm. Next state: LOAD, MOV, OPA, or DONE (for NOP).
- LOAD: `enbIn`=1, `inData`=imm, ld[dst]=1. Next state DONE.
- MOV: enb[src1]=1, ld[dst]=1. If src1==dst, no enables and no loads. Next state DONE.
- ADD operand normalisation:
  - If src1==B or src2==A, then p=src2 and q=src1.
  - Otherwise p=src1 and q=src2.
- OPA: enb[p]=1 and ldA=1. Skipped (no strobes) if p==A.
- OPB: enb[q]=1 and ldB=1. Skipped if q==B.
- A skipped state still consumes its cycle, so ADD latency is fixed.
- SETTLE: `enbAdd`=`enbBusA`=1, no loads.
- WB: `enbAdd`=`enbBusA`=1 and ld[dst]=1. Next state DONE.
- DONE: `done`=1. Next state IDLE.
- ADD clobbers A and B, which act as scratch. The result is (p+q) mod 2^WIDTH; carry is discarded.
- Invariant: at most one of {enbIn, enbA..D, enbBusA} is high in any cycle.
- `inData` holds the last immediate. It is only meaningful while `enbIn`=1.

## Timing
- Reset (synchronous): state=IDLE, `ready`=1, `done`=0, all enables and loads 0, `inData`=0.
- Reset in any state aborts the instruction. Outputs are at reset values from the cycle after the reset edge, and no partial `done` is issued.
- Edge-to-edge latency, from the `start` capture edge to the edge where `done` goes high:
  - NOP: 1 cycle.
  - LOAD and MOV: 2 cycles.
  - ADD: 5 cycles (4 with the macro disabled).
- `ready` returns to 1 the cycle after `done`.
- `start` while `ready`=0 is ignored and is not queued.
- Instruction inputs are sampled only at acceptance. Later changes have no effect.

## Configuration
- `BUS_SEQ_SETTLE_EN` defined: the SETTLE state is present. The adder drives the bus for one cycle before the WB load.
- Undefined: OPB goes directly to WB. Write-back occurs in the first adder-drive cycle, and ADD latency drops to 4.

## Test plan
- Reset, then LOAD A=0x004F, C=0x000F, B=0x003F, D=0x0028. Expect each `done` 2 cycles after `start`, and datapath registers equal to these values.
- ADD A=A+B from that state. Expect A=0x008E and B=0x003F, both OPA and OPB skipped, and `done` at +5 (+4 without the macro).
- Then ADD C=B+D, expecting C=0x0067. Then ADD D=D+C, expecting D=0x008F.
- MOVE B←C, expecting B=0x0067. MOVE A←A, expecting no enables asserted and `done` at +2.
- ADD B=B+A with A=0xFFFF and B=0x0001. Expect swapped operands with no transfer cycles, and B=0x0000 (wrap).
- Assert `reset` during OPB of an ADD. Expect all outputs 0 the next cycle, `ready`=1, and no `done`. Also `start` pulsed while busy is ignored.
- Throughout every test: assert no cycle has more than one bus driver enabled.
